// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the unified single-port memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (port 0) otherwise.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_req0,
    input  logic                  i_we0,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    output logic                  o_done0,
    output logic [DATA_WIDTH-1:0] o_rdata0,
    output logic                  o_stall0,
    input  logic                  i_req1,
    input  logic                  i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic                  o_done1,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [1:0]            o_grant,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_latency_range
        $error("mem_arbiter: MEM_LATENCY must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_q, last_d;      // 1: port 1 was granted last
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  pick1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick1 = i_req1 & (~i_req0 | ~last_q);
`else
        pick1 = i_req1 & ~i_req0;
`endif

        unique case (state_q)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    last_d  = pick1;
                    we_d    = pick1 ? i_we1 : i_we0;
                    addr_d  = pick1 ? i_addr1 : i_addr0;
                    wdata_d = pick1 ? i_wdata1 : i_wdata0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Count reaches zero exactly when the memory presents read data.
                if (cnt_q == '0) begin
                    if (grant_q[1]) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_grant   = grant_q;
    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign o_done0   = (state_q == RESP) & grant_q[0];
    assign o_done1   = (state_q == RESP) & grant_q[1];
    assign o_rdata0  = rdata0_q;
    assign o_rdata1  = rdata1_q;
    assign o_stall0  = i_req0 & ~o_done0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level reference model, memory responder,
// per-cycle monitor. Honours MEM_ARB_ROUND_ROBIN_EN in the reference arbitration.
module tb_mem_arbiter;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 3;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
        int            drop_at;
    } cmd_t;

    typedef struct {
        int            cyc;
        logic          we;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    req = '0;
    logic [1:0]    we = '0;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic          done0, done1, stall0, mem_en, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    grant;
    logic [1:0]    done_v;

    assign done_v = {done1, done0};

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req0   (req[0]),
        .i_we0    (we[0]),
        .i_addr0  (addr[0]),
        .i_wdata0 (wdata[0]),
        .o_done0  (done0),
        .o_rdata0 (rdata0),
        .o_stall0 (stall0),
        .i_req1   (req[1]),
        .i_we1    (we[1]),
        .i_addr1  (addr[1]),
        .i_wdata1 (wdata[1]),
        .o_done1  (done1),
        .o_rdata1 (rdata1),
        .o_grant  (grant),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    cmd_t          cmdq [2][$];
    exp_t          expq [2][$];
    logic [DW-1:0] exp_rd [2];
    logic [1:0]    exp_done_now = '0;
    logic [1:0]    busy = '0;
    int            wait_cnt [2];
    int            busy_cnt [2];
    cmd_t          cur [2];

    // Reference model state: arbiter free from cycle free_at; current grant window.
    int            free_at = 0;
    int            win_start = -10;
    int            win_end = -10;
    int            win_port = 0;
    logic          win_we = 1'b0;
    logic [AW-1:0] win_addr = '0;
    logic [DW-1:0] win_wdata = '0;
    logic [DW-1:0] ref_mem [16];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          last_port = 1'b1;
`endif

    logic [DW-1:0] mem_arr [16];
    logic [LAT-1:0] vpipe = '0;
    logic [DW-1:0] dpipe [LAT];
    logic [DW-1:0] junk = '0;

    assign mem_rdata = vpipe[LAT-1] ? dpipe[LAT-1] : junk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int gap, input int drop);
        cmd_t c;
        c.we = w; c.addr = a; c.wdata = d; c.gap = gap; c.drop_at = drop;
        cmdq[p].push_back(c);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_done0"}, done0, 0);
        chk({tag, "_done1"}, done1, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_rdata0"}, rdata0, 0);
        chk({tag, "_rdata1"}, rdata1, 0);
    endtask

    function automatic logic all_idle();
        return cmdq[0].size() == 0 && cmdq[1].size() == 0 && busy == 2'b00 &&
               expq[0].size() == 0 && expq[1].size() == 0;
    endfunction

    task automatic drain();
        int n = 0;
        while (n < 3000 && !all_idle()) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!all_idle()) begin
            errors++;
            $display("FAIL drain: traffic still pending after %0d cycles, required idle", n);
        end
        repeat (2) @(negedge clk);
    endtask

    // Memory responder: write at the strobe, read data valid LAT cycles later, junk otherwise.
    initial begin
        for (int i = 0; i < 16; i++) mem_arr[i] = 32'hC0DE_0000 | 32'(i);
        for (int i = 0; i < int'(LAT); i++) dpipe[i] = '0;
        forever begin
            @(posedge clk);
            junk  <= $urandom();
            vpipe <= (vpipe << 1) | LAT'(mem_en & ~mem_we);
            for (int i = int'(LAT) - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
            dpipe[0] <= mem_arr[mem_addr[5:2]];
            if (mem_en && mem_we) mem_arr[mem_addr[5:2]] = mem_wdata;
        end
    end

    // Reference model: transactions are serialised; each grant fixes its done cycle.
    initial begin
        int   p;
        int   idx;
        exp_t e;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        forever begin
            @(posedge clk);
            if (reset_n && cyc >= free_at && req != 2'b00) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (req == 2'b11) p = last_port ? 0 : 1;
                else              p = req[1] ? 1 : 0;
                last_port = (p == 1);
`else
                p = req[0] ? 0 : 1;
`endif
                idx    = int'(addr[p][5:2]);
                e.we   = we[p];
                e.cyc  = cyc + 2 + (we[p] ? 0 : int'(LAT));
                e.data = we[p] ? '0 : ref_mem[idx];
                if (we[p]) ref_mem[idx] = wdata[p];
                expq[p].push_back(e);
                win_start = cyc + 1;
                win_end   = e.cyc;
                win_port  = p;
                win_we    = we[p];
                win_addr  = addr[p];
                win_wdata = wdata[p];
                free_at   = e.cyc + 1;
            end
            cyc++;
        end
    end

    // Reset abandons everything in flight.
    initial begin
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        forever begin
            @(negedge reset_n);
            free_at   = 0;
            win_start = -10;
            win_end   = -10;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_port = 1'b1;
`endif
            expq[0].delete();
            expq[1].delete();
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end
    end

    // Requesters: hold each request until its done pulse, optionally dropping it early.
    initial begin
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0; wdata[p] = '0; wait_cnt[p] = 0; busy_cnt[p] = 0;
        end
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!reset_n) begin
                    busy[p] = 1'b0; req[p] = 1'b0; wait_cnt[p] = 0;
                end else begin
                    if (busy[p]) begin
                        busy_cnt[p]++;
                        if (done_v[p] || busy_cnt[p] > 200) begin
                            busy[p] = 1'b0; req[p] = 1'b0;
                        end else if (cur[p].drop_at != 0 && busy_cnt[p] == cur[p].drop_at) begin
                            req[p] = 1'b0;
                        end
                    end
                    if (!busy[p] && cmdq[p].size() != 0) begin
                        if (wait_cnt[p] < cmdq[p][0].gap) begin
                            wait_cnt[p]++;
                        end else begin
                            cur[p]      = cmdq[p].pop_front();
                            req[p]      = 1'b1;
                            we[p]       = cur[p].we;
                            addr[p]     = cur[p].addr;
                            wdata[p]    = cur[p].wdata;
                            busy[p]     = 1'b1;
                            busy_cnt[p] = 0;
                            wait_cnt[p] = 0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on done, checks grant/memory/stall every cycle.
    initial begin
        exp_t       e;
        logic [1:0] eg;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                for (int p = 0; p < 2; p++) begin
                    while (expq[p].size() != 0 && expq[p][0].cyc < cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL done%0d_missing: expected at cycle %0d, not observed", p, expq[p][0].cyc);
                        void'(expq[p].pop_front());
                    end
                    exp_done_now[p] = expq[p].size() != 0 && expq[p][0].cyc == cyc;
                    chk($sformatf("done%0d", p), done_v[p], exp_done_now[p]);
                    if (exp_done_now[p]) begin
                        e = expq[p].pop_front();
                        if (!e.we) exp_rd[p] = e.data;
                    end
                end
                chk("rdata0", rdata0, exp_rd[0]);
                chk("rdata1", rdata1, exp_rd[1]);
                eg = (cyc >= win_start && cyc <= win_end) ? (win_port == 1 ? 2'b10 : 2'b01) : 2'b00;
                chk("grant", grant, eg);
                chk("mem_en", mem_en, cyc == win_start);
                chk("mem_we", mem_we, cyc == win_start && win_we);
                if (cyc == win_start) begin
                    chk("mem_addr", mem_addr, win_addr);
                    if (win_we) chk("mem_wdata", mem_wdata, win_wdata);
                end
                #1;
                chk("stall0", stall0, req[0] & ~exp_done_now[0]);
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        #2 reset_n = 1'b1;

        push(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 0);
        drain();
        push(1, 1'b0, 32'h10, '0, 0, 0);
        drain();

        for (int i = 0; i < 10; i++) begin
            push(0, (i % 2) == 0, 32'(i) << 2, $urandom(), 0, 0);
            push(1, (i % 3) == 0, 32'(i + 5) << 2, $urandom(), 0, 0);
        end
        drain();

        push(0, 1'b0, 32'h10, '0, 0, 0);
        push(1, 1'b0, 32'h14, '0, 2, 0);
        drain();

        push(0, 1'b0, 32'h10, '0, 0, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_en && n < 20);
        chk("reset_test_issue", mem_en, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        push(0, 1'b0, 32'h10, '0, 0, 0);
        drain();

        push(0, 1'b0, 32'h14, '0, 0, 2);
        drain();

        for (int i = 0; i < 40; i++) begin
            push(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom(),
                 int'($urandom_range(0, 3)), 0);
            push(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom(),
                 int'($urandom_range(0, 3)), 0);
        end
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
